frame_dump_trigger: RTL and testbench
=====================================

# frame_dump_trigger

- Synthesizable frame counter and waveform-dump window generator.
- Watches the game's vertical sync and the ROM-download indicator.
- Produces the frame count and the dump start/stop strobes that the simulation dump controller consumes, so the trigger decision is made by RTL instead of testbench-only code.
- Sits in the test harness next to the game top, driven by the video timing generator's VS output and the downloader's busy signal.

## Interface
- `START`, default 0: frame number at which the dump window opens.
- `LEN`, default 0: window length in frames; 0 means the window never closes.
- `clk` input 1: system clock; all logic runs on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `vga_vs` input 1: vertical sync, asynchronous to `clk`; active-low pulse, frame boundary on the falling edge.
- `downloading` input 1: ROM download in progress, asynchronous to `clk`.
- `frame_cnt` output 32: frames seen since reset or since download end.
- `dump_en` output 1: high while the dump window is open.
- `dump_start` output 1: one-cycle pulse when the window opens.
- `dump_stop` output 1: one-cycle pulse when the window closes.

## Operation
- **Synchronisers:** `vga_vs` and `downloading` each pass through a 2-FF synchroniser. A third register per signal feeds edge detection.
- **Frame event (`fev`):** synchronised `vga_vs` is 0 and its delayed copy is 1.
- **Download end (`dlend`):** synchronised `downloading` falls.
- **Download start (`dlstart`):** synchronised `downloading` rises.
- **Frame counter:** `frame_cnt` increments by 1 on every `fev` and wraps from `32'hFFFFFFFF` to 0.
- **States:** WAIT_DL, WAIT_START, ACTIVE, DONE. The reset state is set by the configuration macro.
- **WAIT_DL:**
  - On `dlend`, clear `frame_cnt` to 0 and go to WAIT_START.
  - `fev` in WAIT_DL still counts.
- **WAIT_START:**
  - On `fev` with the pre-increment `frame_cnt == START`: pulse `dump_start`, set `dump_en`, clear the window counter `wcnt` (32 bit), go to ACTIVE.
  - The comparison is equality only. If START is already passed, the window opens after the counter wraps.
- **ACTIVE:**
  - Each `fev` increments `wcnt`.
  - If `LEN != 0` and the post-increment `wcnt == LEN`: pulse `dump_stop`, clear `dump_en`, go to DONE.
- **DONE:** terminal until reset, or until `dlstart` when the macro is defined.
- **Simultaneous `fev` and `dlend` in WAIT_DL:** `dlend` wins and `frame_cnt` becomes 0, not 1.
- **Simultaneous `fev` and `dlstart`:** `dlstart` wins and `frame_cnt` is not incremented.
- **Reset mid-window:** all outputs clear asynchronously; no `dump_stop` is emitted.

## Timing
- **Reset values:** `frame_cnt`=0, `dump_en`=0, `dump_start`=0, `dump_stop`=0, `wcnt`=0.
- **Frame latency:** `vga_vs` sampled low at edge N gives `fev` at edge N+2. `frame_cnt`, `dump_start` and `dump_en` update at edge N+3, all in the same cycle.
- **Download latency:** `downloading` transitions have the same 3-cycle latency to their effects.
- **Pulse width:** `dump_start` and `dump_stop` are exactly one `clk` cycle wide. They are never high in the same cycle.
- **`dump_en` alignment:** rises in the cycle of `dump_start` and falls in the cycle of `dump_stop`.
- **Input hold:** `vga_vs` low and high phases must each last at least 3 `clk` cycles to be counted once.

## Configuration
- **`DUMP_LOADROM_EN` defined:**
  - Reset state is WAIT_DL.
  - In WAIT_START, ACTIVE or DONE, `dlstart` goes to WAIT_DL. From ACTIVE it also pulses `dump_stop` and clears `dump_en` in that cycle.
- **`DUMP_LOADROM_EN` undefined:**
  - Reset state is WAIT_START.
  - `downloading` is ignored entirely, and its synchroniser is not built.

## Test plan
- **Basic window:** START=3, LEN=2, macro undefined; 8 VS pulses → `dump_start` on the 4th `fev` (`frame_cnt` 3→4); `dump_stop` on the 6th `fev`; `dump_en` high exactly 2 frames; `frame_cnt` ends at 8.
- **Unlimited window:** START=0, LEN=0; 5 VS pulses → `dump_start` on the 1st `fev`; `dump_en` stays high; `dump_stop` never pulses.
- **Download gating:** macro defined, START=1, LEN=1; 3 VS pulses during download, then download ends → `frame_cnt` 3 then 0; no start until the 2nd post-download `fev`; stop on the 3rd.
- **Download restart mid-window:** macro defined; `downloading` rises while ACTIVE → one `dump_stop` pulse, `dump_en`=0, state WAIT_DL; `fev` during the same cycle does not increment `frame_cnt`.
- **Async reset mid-window:** assert `rst_n` low asynchronously during ACTIVE → all outputs 0 immediately, no `dump_stop`; after release, a window reopens at START.
- **Wrap-around:** force `frame_cnt` to `32'hFFFFFFFE` with START=0; 2 `fev` → count 0 with no start; the 3rd `fev` opens the window.

Source files
------------

// File: rtl/frame_dump_trigger.sv
// frame_dump_trigger: counts video frames and opens a waveform-dump window.
// A window opens at frame START and lasts LEN frames. LEN = 0 keeps it open.
// Optional feature macro: DUMP_LOADROM_EN. When it is defined, the window is
// gated by the ROM downloader: counting restarts when a download ends, and a
// new download closes the window.
module frame_dump_trigger #(
  parameter logic [31:0] START = 32'd0,
  parameter logic [31:0] LEN   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_vs,
  input  logic        downloading,
  output logic [31:0] frame_cnt,
  output logic        dump_en,
  output logic        dump_start,
  output logic        dump_stop
);

  localparam logic [1:0] S_WAIT_DL    = 2'd0;
  localparam logic [1:0] S_WAIT_START = 2'd1;
  localparam logic [1:0] S_ACTIVE     = 2'd2;
  localparam logic [1:0] S_DONE       = 2'd3;
`ifdef DUMP_LOADROM_EN
  localparam logic [1:0] S_RESET = S_WAIT_DL;
`else
  localparam logic [1:0] S_RESET = S_WAIT_START;
`endif

  logic [2:0]  vs_q;   // [0],[1] synchroniser, [2] delayed copy for edges
  logic        fev_q;
  logic        dlend_ev, dlstart_ev;
  logic [1:0]  state_q, state_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic        dump_en_q, dump_en_d;
  logic        dump_start_q, dump_start_d;
  logic        dump_stop_q, dump_stop_d;

  // VS synchroniser and registered falling-edge (frame boundary) event.
  // VS idles high, so reset to 1 to avoid a false frame after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 3'b111;
      fev_q <= 1'b0;
    end else begin
      vs_q  <= {vs_q[1:0], vga_vs};
      fev_q <= ~vs_q[1] & vs_q[2];
    end
  end

`ifdef DUMP_LOADROM_EN
  logic [2:0] dl_q;
  logic       dlend_q, dlstart_q;

  // Downloader synchroniser with registered rise/fall events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q      <= 3'b000;
      dlend_q   <= 1'b0;
      dlstart_q <= 1'b0;
    end else begin
      dl_q      <= {dl_q[1:0], downloading};
      dlend_q   <= ~dl_q[1] & dl_q[2];
      dlstart_q <= dl_q[1] & ~dl_q[2];
    end
  end

  assign dlend_ev   = dlend_q;
  assign dlstart_ev = dlstart_q;
`else
  // The downloader is ignored in this build.
  logic dl_unused;
  assign dl_unused  = downloading;
  assign dlend_ev   = 1'b0;
  assign dlstart_ev = 1'b0;
`endif

  // Next-state logic. A download start overrides everything (no count);
  // a download end in WAIT_DL overrides a coincident frame.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    wcnt_d       = wcnt_q;
    dump_en_d    = dump_en_q;
    dump_start_d = 1'b0;
    dump_stop_d  = 1'b0;
    if (dlstart_ev) begin
      state_d = S_WAIT_DL;
      if (state_q == S_ACTIVE) begin
        dump_stop_d = 1'b1;
        dump_en_d   = 1'b0;
      end
    end else if (state_q == S_WAIT_DL && dlend_ev) begin
      frame_cnt_d = 32'd0;
      state_d     = S_WAIT_START;
    end else if (fev_q) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
      case (state_q)
        S_WAIT_START: begin
          if (frame_cnt_q == START) begin
            dump_start_d = 1'b1;
            dump_en_d    = 1'b1;
            wcnt_d       = 32'd0;
            state_d      = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          wcnt_d = wcnt_q + 32'd1;
          if (LEN != 32'd0 && wcnt_d == LEN) begin
            dump_stop_d = 1'b1;
            dump_en_d   = 1'b0;
            state_d     = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      frame_cnt_q  <= 32'd0;
      wcnt_q       <= 32'd0;
      dump_en_q    <= 1'b0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      wcnt_q       <= wcnt_d;
      dump_en_q    <= dump_en_d;
      dump_start_q <= dump_start_d;
      dump_stop_q  <= dump_stop_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign dump_en    = dump_en_q;
  assign dump_start = dump_start_q;
  assign dump_stop  = dump_stop_q;

endmodule

// File: tb/tb_frame_dump_trigger.sv
// Bench for frame_dump_trigger: three instances with different windows share
// the same VS/download stimulus. Stimulus pushes the expected outputs (with
// the cycle they are due) into per-instance queues; the monitor compares them
// and checks outputs hold steady with no pulses in all other cycles.
module tb_frame_dump_trigger;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vga_vs = 1'b1;
  logic downloading = 1'b0;
  logic [31:0] fc [3];
  logic en [3], st [3], sp [3];

`ifdef DUMP_LOADROM_EN
  localparam bit DLEN = 1'b1;
`else
  localparam bit DLEN = 1'b0;
`endif

  always #5 clk = ~clk;

  frame_dump_trigger #(.START(32'd3), .LEN(32'd2)) u0 (.clk(clk), .rst_n(rst_n),
    .vga_vs(vga_vs), .downloading(downloading), .frame_cnt(fc[0]),
    .dump_en(en[0]), .dump_start(st[0]), .dump_stop(sp[0]));
  frame_dump_trigger #(.START(32'd0), .LEN(32'd0)) u1 (.clk(clk), .rst_n(rst_n),
    .vga_vs(vga_vs), .downloading(downloading), .frame_cnt(fc[1]),
    .dump_en(en[1]), .dump_start(st[1]), .dump_stop(sp[1]));
  frame_dump_trigger #(.START(32'd1), .LEN(32'd1)) u2 (.clk(clk), .rst_n(rst_n),
    .vga_vs(vga_vs), .downloading(downloading), .frame_cnt(fc[2]),
    .dump_en(en[2]), .dump_start(st[2]), .dump_stop(sp[2]));

  typedef struct {
    int          when;
    logic [31:0] cnt;
    bit          en, st, sp;
  } exp_t;

  exp_t        sb [3][$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  // Reference model: window bookkeeping per instance.
  bit          m_dl [3], m_open [3], m_done [3];
  logic [31:0] m_cnt [3], m_wcnt [3];
  logic [31:0] h_cnt [3];
  bit          h_en [3];

  function automatic logic [31:0] p_start(int i);
    return (i == 0) ? 32'd3 : (i == 1) ? 32'd0 : 32'd1;
  endfunction
  function automatic logic [31:0] p_len(int i);
    return (i == 0) ? 32'd2 : (i == 1) ? 32'd0 : 32'd1;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s u%0d @cyc %0d: got %h want %h", name, i, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_dl[i] = DLEN; m_open[i] = 0; m_done[i] = 0;
      m_cnt[i] = 0; m_wcnt[i] = 0; h_cnt[i] = 0; h_en[i] = 0;
      sb[i].delete();
    end
  endtask

  task automatic model_step(input int when, input bit fev, input bit dle, input bit dls);
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      bit s, p;
      s = 0; p = 0;
      if (dls) begin
        if (m_open[i]) p = 1;
        m_open[i] = 0; m_done[i] = 0; m_dl[i] = 1;
      end else if (m_dl[i] && dle) begin
        m_cnt[i] = 0; m_dl[i] = 0;
      end else if (fev) begin
        if (!m_dl[i] && !m_open[i] && !m_done[i] && m_cnt[i] == p_start(i)) begin
          s = 1; m_open[i] = 1; m_wcnt[i] = 0;
        end else if (m_open[i]) begin
          m_wcnt[i] = m_wcnt[i] + 1;
          if (p_len(i) != 0 && m_wcnt[i] == p_len(i)) begin
            p = 1; m_open[i] = 0; m_done[i] = 1;
          end
        end
        m_cnt[i] = m_cnt[i] + 1;
      end
      e.when = when; e.cnt = m_cnt[i]; e.en = m_open[i]; e.st = s; e.sp = p;
      sb[i].push_back(e);
    end
  endtask

  // Monitor: sample 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sb[i].size() > 0 && sb[i][0].when <= cyc) begin
          exp_t e;
          e = sb[i].pop_front();
          chk("latency", i, cyc, e.when);
          chk("frame_cnt", i, fc[i], e.cnt);
          chk("dump_en", i, {31'd0, en[i]}, {31'd0, e.en});
          chk("dump_start", i, {31'd0, st[i]}, {31'd0, e.st});
          chk("dump_stop", i, {31'd0, sp[i]}, {31'd0, e.sp});
          h_cnt[i] = e.cnt; h_en[i] = e.en;
        end else begin
          chk("idle_cnt", i, fc[i], h_cnt[i]);
          chk("idle_en", i, {31'd0, en[i]}, {31'd0, h_en[i]});
          chk("idle_start", i, {31'd0, st[i]}, 32'd0);
          chk("idle_stop", i, {31'd0, sp[i]}, 32'd0);
        end
      end
    end
  end

  // One VS pulse; optionally toggles the downloader in the same cycle.
  task automatic drive_frame(input bit dl_toggle);
    bit dle, dls;
    int e;
    @(negedge clk);
    e = cyc + 1;
    dle = 0; dls = 0;
    vga_vs = 1'b0;
    if (dl_toggle) begin
      downloading = ~downloading;
      dls = DLEN & downloading;
      dle = DLEN & ~downloading;
    end
    model_step(e + 3, 1'b1, dle, dls);
    repeat ($urandom_range(3, 6)) @(negedge clk);
    vga_vs = 1'b1;
    repeat ($urandom_range(4, 8)) @(negedge clk);
  endtask

  task automatic dl_set(input bit v);
    int e;
    if (v != downloading) begin
      @(negedge clk);
      e = cyc + 1;
      downloading = v;
      model_step(e + 3, 1'b0, DLEN & ~v, DLEN & v);
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    downloading = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_cnt", i, fc[i], 32'd0);
      chk("rst_en", i, {31'd0, en[i]}, 32'd0);
      chk("rst_start", i, {31'd0, st[i]}, 32'd0);
      chk("rst_stop", i, {31'd0, sp[i]}, 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1);
  end

  initial begin
    model_reset();
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_cnt", i, fc[i], 32'd0);
      chk("rst_en", i, {31'd0, en[i]}, 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Download gating, then the basic and unlimited windows.
    dl_set(1'b1);
    repeat (3) drive_frame(1'b0);
    dl_set(1'b0);
    repeat (8) drive_frame(1'b0);

    // Download restarts while u1's unlimited window is open, with a
    // coincident frame; it then ends on a coincident frame.
    drive_frame(1'b1);
    repeat (2) drive_frame(1'b0);
    drive_frame(1'b1);
    repeat (4) drive_frame(1'b0);

    // Reset in the middle of open windows, then reopen.
    reset_dut();
    dl_set(1'b1);
    dl_set(1'b0);
    repeat (2) drive_frame(1'b0);
    reset_dut();
    dl_set(1'b1);
    dl_set(1'b0);
    repeat (6) drive_frame(1'b0);

    // Wrap-around of the frame counter on u1 (START = 0).
    reset_dut();
    dl_set(1'b1);
    dl_set(1'b0);
    @(negedge clk);
    force u1.frame_cnt_q = 32'hFFFFFFFE;
    m_cnt[1] = 32'hFFFFFFFE;
    h_cnt[1] = 32'hFFFFFFFE;
    @(negedge clk);
    release u1.frame_cnt_q;
    repeat (2) drive_frame(1'b0);
    chk("wrap_cnt", 1, fc[1], 32'd0);
    chk("wrap_closed", 1, {31'd0, en[1]}, 32'd0);
    drive_frame(1'b0);
    chk("wrap_open", 1, {31'd0, en[1]}, 32'd1);

    // Randomised mix of frames, coincident toggles and download edges.
    reset_dut();
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) drive_frame(1'b0);
      else if (r < 8) drive_frame(1'b1);
      else dl_set(~downloading);
    end

    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("drain", i, sb[i].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
